// File: rtl/pc_register_unit.sv
// PC/EPC register stage with branch resolution and PC word-alignment check.
// Optional taken/evaluated branch counters are enabled by defining PC_PERF_CNT_EN.
module pc_register_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_next,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic [1:0]       branch_op,
  input  logic             alu_zero,
  input  logic             alu_gt,
  input  logic             epc_write,
  input  logic [31:0]      epc_in,
  output logic [31:0]      pc,
  output logic [31:0]      epc,
  output logic             branch_taken,
  output logic             misalign_exc,
  output logic [31:0]      bad_vaddr,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] branch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;
  logic        branch_taken_q, branch_taken_d;
  logic        misalign_exc_q, misalign_exc_d;
  logic        cond;
  logic        load_req;
  logic        misaligned;

  always_comb begin
    cond = 1'b0;
    case (branch_op)
      2'b00:   cond = alu_zero;
      2'b01:   cond = ~alu_zero;
      2'b10:   cond = alu_gt;
      default: cond = ~alu_gt;
    endcase
  end

  assign load_req   = pc_write | (pc_write_cond & cond);
  assign misaligned = ALIGN_CHECK && (pc_next[1:0] != 2'b00);

  // A misaligned load leaves the PC alone; the control unit vectors via EPC.
  always_comb begin
    pc_d           = pc_q;
    bad_vaddr_d    = bad_vaddr_q;
    misalign_exc_d = 1'b0;
    branch_taken_d = branch_taken_q;
    epc_d          = epc_q;
    if (load_req && !misaligned) pc_d = pc_next;
    if (load_req && misaligned) begin
      bad_vaddr_d    = pc_next;
      misalign_exc_d = 1'b1;
    end
    if (pc_write_cond) branch_taken_d = cond;
    if (epc_write)     epc_d          = epc_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q           <= RESET_PC;
      epc_q          <= 32'h0;
      bad_vaddr_q    <= 32'h0;
      branch_taken_q <= 1'b0;
      misalign_exc_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      bad_vaddr_q    <= bad_vaddr_d;
      branch_taken_q <= branch_taken_d;
      misalign_exc_q <= misalign_exc_d;
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign bad_vaddr    = bad_vaddr_q;
  assign branch_taken = branch_taken_q;
  assign misalign_exc = misalign_exc_q;

`ifdef PC_PERF_CNT_EN
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    taken_count_d  = taken_count_q;
    branch_count_d = branch_count_q;
    if (pc_write_cond && (branch_count_q != {CNT_W{1'b1}}))
      branch_count_d = branch_count_q + CNT_W'(1);
    if (pc_write_cond && cond && (taken_count_q != {CNT_W{1'b1}}))
      taken_count_d = taken_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_count_q  <= '0;
      branch_count_q <= '0;
    end else begin
      taken_count_q  <= taken_count_d;
      branch_count_q <= branch_count_d;
    end
  end

  assign taken_count  = taken_count_q;
  assign branch_count = branch_count_q;
`else
  assign taken_count  = '0;
  assign branch_count = '0;
`endif

endmodule

// File: tb/tb_pc_register_unit.sv
// Randomized + directed bench for pc_register_unit against a behavioural model.
// Instance u_dut checks alignment; u_dut_na has ALIGN_CHECK=0.
module tb_pc_register_unit;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  // Clock/reset and stimulus signals
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      pc_next = '0;
  logic             pc_write = 1'b0;
  logic             pc_write_cond = 1'b0;
  logic [1:0]       branch_op = '0;
  logic             alu_zero = 1'b0;
  logic             alu_gt = 1'b0;
  logic             epc_write = 1'b0;
  logic [31:0]      epc_in = '0;

  logic [31:0]      pc, epc, bad_vaddr;
  logic             branch_taken, misalign_exc;
  logic [CNT_W-1:0] taken_count, branch_count;
  logic [31:0]      pc2, epc2, bad_vaddr2;
  logic             branch_taken2, misalign_exc2;
  logic [CNT_W-1:0] taken_count2, branch_count2;

  always #5 clk = ~clk;

  pc_register_unit #(.RESET_PC(RESET_PC), .ALIGN_CHECK(1'b1), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .epc_write(epc_write), .epc_in(epc_in), .pc(pc), .epc(epc),
    .branch_taken(branch_taken), .misalign_exc(misalign_exc), .bad_vaddr(bad_vaddr),
    .taken_count(taken_count), .branch_count(branch_count)
  );

  pc_register_unit #(.RESET_PC(RESET_PC), .ALIGN_CHECK(1'b0), .CNT_W(CNT_W)) u_dut_na (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
    .alu_gt(alu_gt), .epc_write(epc_write), .epc_in(epc_in), .pc(pc2), .epc(epc2),
    .branch_taken(branch_taken2), .misalign_exc(misalign_exc2), .bad_vaddr(bad_vaddr2),
    .taken_count(taken_count2), .branch_count(branch_count2)
  );

  // Scoreboard / reference model state
  logic [31:0] exp_q[$];
  logic [31:0] m_pc, m_epc, m_bad, m2_pc;
  logic        m_bt, m_exc;
  int          m_tc, m_bc;
  int          checks = 0;
  int          failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit branch_rule(input logic [1:0] op, input logic z, input logic g);
    case (op)
      2'd0:    return z;
      2'd1:    return !z;
      2'd2:    return g;
      default: return !g;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m2_pc = RESET_PC; m_epc = '0; m_bad = '0;
    m_bt = 1'b0; m_exc = 1'b0; m_tc = 0; m_bc = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_pc;
    exp_pc = exp_q.pop_front();
    check_val({tag, ".pc"}, pc, exp_pc);
    check_val({tag, ".epc"}, epc, m_epc);
    check_val({tag, ".taken"}, 32'(branch_taken), 32'(m_bt));
    check_val({tag, ".exc"}, 32'(misalign_exc), 32'(m_exc));
    check_val({tag, ".bad"}, bad_vaddr, m_bad);
`ifdef PC_PERF_CNT_EN
    check_val({tag, ".tcnt"}, 32'(taken_count), 32'(m_tc));
    check_val({tag, ".bcnt"}, 32'(branch_count), 32'(m_bc));
`else
    check_val({tag, ".tcnt"}, 32'(taken_count), 32'h0);
    check_val({tag, ".bcnt"}, 32'(branch_count), 32'h0);
`endif
    check_val({tag, ".na_pc"}, pc2, m2_pc);
    check_val({tag, ".na_exc"}, 32'(misalign_exc2), 32'h0);
    check_val({tag, ".na_bad"}, bad_vaddr2, 32'h0);
  endtask

  // Driver: apply one cycle of inputs on the falling edge, predict, check after the edge.
  task automatic cycle(input string tag, input logic pw, input logic pwc, input logic [1:0] op,
                       input logic z, input logic g, input logic ew,
                       input logic [31:0] nxt, input logic [31:0] ein);
    bit taken, want, odd;
    @(negedge clk);
    pc_write = pw; pc_write_cond = pwc; branch_op = op; alu_zero = z; alu_gt = g;
    epc_write = ew; pc_next = nxt; epc_in = ein;
    taken = branch_rule(op, z, g);
    want  = pw || (pwc && taken);
    odd   = (nxt % 4) != 0;
    if (want && !odd) m_pc = nxt;
    if (want) m2_pc = nxt;
    m_exc = want && odd;
    if (want && odd) m_bad = nxt;
    if (pwc) begin
      m_bt = taken;
      if (m_bc < CNT_MAX) m_bc++;
      if (taken && m_tc < CNT_MAX) m_tc++;
    end
    if (ew) m_epc = ein;
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    exp_q.push_back(m_pc);
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    cycle("pc4",     1, 0, 2'd0, 0, 0, 0, 32'h4, 32'h0);
    cycle("beq_t",   0, 1, 2'd0, 1, 0, 0, 32'h40, 32'h0);
    cycle("beq_nt",  0, 1, 2'd0, 0, 0, 0, 32'h80, 32'h0);
    cycle("ble_nt",  0, 1, 2'd3, 0, 1, 0, 32'h100, 32'h0);
    cycle("ble_t",   0, 1, 2'd3, 0, 0, 0, 32'h100, 32'h0);
    cycle("bne_t",   0, 1, 2'd1, 0, 0, 0, 32'h120, 32'h0);
    cycle("bgt_t",   0, 1, 2'd2, 0, 1, 0, 32'h140, 32'h0);
    cycle("pw_dom",  1, 1, 2'd0, 0, 0, 0, 32'h200, 32'h0);
    cycle("idle",    0, 0, 2'd0, 1, 1, 0, 32'h300, 32'h0);
    cycle("mis",     1, 0, 2'd0, 0, 0, 0, 32'h102, 32'h0);
    cycle("mis_end", 0, 0, 2'd0, 0, 0, 0, 32'h104, 32'h0);
    cycle("mis_b2b1", 1, 0, 2'd0, 0, 0, 0, 32'h201, 32'h0);
    cycle("mis_b2b2", 0, 1, 2'd0, 1, 0, 0, 32'h303, 32'h0);
    cycle("mis_idle", 0, 1, 2'd0, 0, 0, 0, 32'h305, 32'h0);
    cycle("epc_pc",  1, 0, 2'd0, 0, 0, 1, 32'h8000_0180, 32'h20);

    for (int i = 0; i < 20; i++)
      cycle("sat", 0, 1, 2'd0, 1, 0, 0, 32'h1000 + 32'(i * 4), 32'h0);

    // Asynchronous reset with a write pending overrides everything immediately.
    @(negedge clk);
    pc_write = 1'b1; pc_write_cond = 1'b1; alu_zero = 1'b1; branch_op = 2'd0;
    epc_write = 1'b1; epc_in = 32'h55; pc_next = 32'h0000_0046;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(m_pc);
    check_all("rst_mid");
    @(posedge clk);
    #1;
    exp_q.push_back(m_pc);
    check_all("rst_hold");
    @(negedge clk);
    pc_write = 1'b0; pc_write_cond = 1'b0; epc_write = 1'b0;
    reset = 1'b1;
    cycle("post_rst", 1, 0, 2'd0, 0, 0, 0, 32'h8, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] nxt;
      nxt = $urandom();
      if ($urandom_range(0, 3) != 0) nxt[1:0] = 2'b00;
      cycle("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), nxt, $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_register_unit.md
Name: pc_register_unit

Overview:
Program-counter stage of the multicycle MIPS datapath, directly downstream of the PC-source mux. Holds PC and EPC, and resolves conditional branches from ALU flags into a PC load enable. Checks word alignment of every incoming PC value and raises a misalignment exception pulse toward the control unit. PC output feeds instruction memory and the ALU; EPC output feeds back into the PC-source mux (select 011).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ALIGN_CHECK, 1, 1 = suppress and flag misaligned PC loads; 0 = load any value
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_next  in  32  candidate next PC (PC-source mux output)
pc_write  in  1  unconditional PC load request
pc_write_cond  in  1  conditional PC load request (branch)
branch_op  in  2  00 beq, 01 bne, 10 bgt, 11 ble
alu_zero  in  1  ALU zero flag
alu_gt  in  1  ALU greater-than flag (signed A>B)
epc_write  in  1  EPC load enable
epc_in  in  32  value to store in EPC (normally ALU result PC-4)
pc  out  32  current PC
epc  out  32  current EPC
branch_taken  out  1  registered: last conditional branch was taken
misalign_exc  out  1  one-cycle pulse: misaligned PC load suppressed
bad_vaddr  out  32  offending address of last misaligned load
taken_count  out  CNT_W  taken-branch count (optional feature)
branch_count  out  CNT_W  evaluated-branch count (optional feature)

Behaviour:
- Reset (reset=0, async): pc=RESET_PC; epc=0; branch_taken=0; misalign_exc=0; bad_vaddr=0; counters=0. Release takes effect on next clk edge.
- cond (combinational): beq=alu_zero; bne=~alu_zero; bgt=alu_gt; ble=~alu_gt.
- load_req = pc_write | (pc_write_cond & cond). pc_write dominates; with both asserted PC loads regardless of cond.
- misaligned = ALIGN_CHECK && pc_next[1:0]!=2'b00.
- Edge with load_req & ~misaligned: pc <= pc_next (visible one cycle after request, latency 1).
- Edge with load_req & misaligned: pc holds; bad_vaddr <= pc_next; misalign_exc <= 1 for exactly one cycle. Control FSM then writes EPC and vectors through the mux.
- misalign_exc deasserts on next edge unless another misaligned load_req occurs (back-to-back pulses allowed, bad_vaddr updates each time).
- Edge with pc_write_cond=1: branch_taken <= cond (captured even if pc_write also set). Otherwise branch_taken holds.
- Edge with epc_write: epc <= epc_in. Independent of PC load; same-cycle epc_write and load_req both take effect; epc_in is the pre-edge value, never the new PC.
- No load_req: pc holds; ALU flags ignored.
- ALIGN_CHECK=0: misaligned never asserted; misalign_exc and bad_vaddr stay 0.
- Reset mid-operation overrides all pending writes immediately.

Optional Feature:
Macro PC_PERF_CNT_EN.
- Defined: branch_count increments on every edge with pc_write_cond=1; taken_count increments when pc_write_cond=1 and cond=1. Both saturate at all-ones (no wrap). Reset to 0.
- Undefined: no counter registers; taken_count and branch_count tied to 0. All other behaviour identical.

Test Plan:
- Reset with RESET_PC=32'h0000_0000, release, pc_write=1, pc_next=32'h0000_0004 -> pc=0x4 one cycle later; epc=0, misalign_exc=0.
- pc_write_cond=1, branch_op=00, alu_zero=1, pc_next=0x40 -> pc=0x40, branch_taken=1; repeat with alu_zero=0 -> pc unchanged, branch_taken=0.
- branch_op=11 (ble), alu_gt=1, pc_write_cond=1 -> not taken; alu_gt=0 -> taken; pc_write=1 with cond false -> PC still loads.
- pc_write=1, pc_next=0x0000_0102 -> pc holds old value, misalign_exc high exactly one cycle, bad_vaddr=0x102; ALIGN_CHECK=0 -> pc=0x102, no pulse.
- epc_write=1, epc_in=0x20, same cycle pc_write=1, pc_next=0x8000_0180 -> epc=0x20, pc=0x8000_0180.
- With PC_PERF_CNT_EN, CNT_W=4: 20 taken branches -> taken_count=15 (saturated), branch_count=15; assert reset mid-sequence -> both 0 immediately.
